reg_wb_arbiter: RTL and testbench

- Owns the single write port of the register file.
- Arbitrates between two writers:
  - the pipeline write-back stage (fixed priority, no back-pressure)
  - the multi-cycle custom-instruction unit (valid/ready)
- Runs a post-reset clear sequence that zeroes every register through the normal write port.
- Stalls the pipeline during the clear sequence and when the custom unit is starved; sits between WB/custom unit and the register file.

---
 rtl/reg_wb_arbiter_pkg.sv | 28 ++
 rtl/reg_wb_arbiter_if.sv | 41 ++++
 rtl/reg_clear_seq.sv | 42 ++++
 rtl/reg_wb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_reg_wb_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_wb_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Module      : reg_wb_arbiter_pkg
// Description : Shared sizes and arbiter state encoding for the register-file
//               write-port arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
package reg_wb_arbiter_pkg;

   // Aliases of the core-wide register-file sizing
   localparam int unsigned C_WORD_LEN       = 32;
   localparam int unsigned C_ADDR_LEN       = 5;
   localparam int unsigned C_REG_FILE_SIZE  = 32;
   localparam int unsigned C_STARVE_LIMIT   = 4;

   // Arbiter state encoding
   localparam logic [1:0] C_ST_CLEAR = 2'd0;
   localparam logic [1:0] C_ST_RUN   = 2'd1;
   localparam logic [1:0] C_ST_FORCE = 2'd2;

   typedef enum logic [1:0] {
      ST_CLEAR = C_ST_CLEAR,
      ST_RUN   = C_ST_RUN,
      ST_FORCE = C_ST_FORCE
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/reg_wb_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module      : reg_wb_arbiter_if
// Description : Write-back, custom-unit and register-file port bundle of the
//               write-port arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
interface reg_wb_arbiter_if
   import reg_wb_arbiter_pkg::*;
#(
   parameter int WORD_LEN = C_WORD_LEN,
   parameter int ADDR_LEN = C_ADDR_LEN
);

   logic                wbEn;
   logic [ADDR_LEN-1:0] wbDest;
   logic [WORD_LEN-1:0] wbVal;
   logic                cuValid;
   logic [ADDR_LEN-1:0] cuDest;
   logic [WORD_LEN-1:0] cuVal;
   logic                cuReady;
   logic                stall;
   logic                busy;
   logic                regWriteEn;
   logic [ADDR_LEN-1:0] regDest;
   logic [WORD_LEN-1:0] regWriteVal;

   // Arbiter side: receives requests, drives the register file
   modport slave (
      input  wbEn, wbDest, wbVal, cuValid, cuDest, cuVal,
      output cuReady, stall, busy, regWriteEn, regDest, regWriteVal
   );

   // Requester / observer side
   modport master (
      output wbEn, wbDest, wbVal, cuValid, cuDest, cuVal,
      input  cuReady, stall, busy, regWriteEn, regDest, regWriteVal
   );

endinterface
`default_nettype wire

// File: rtl/reg_clear_seq.sv
`default_nettype none
//==============================================================================
// Module      : reg_clear_seq
// Description : Post-reset register clear address generator. Walks the
//               register index from 1 up to REG_FILE_SIZE-1; register 0 is
//               hard-wired and never addressed.
// Revision    : 1.0 - initial release
//==============================================================================
module reg_clear_seq
   import reg_wb_arbiter_pkg::*;
#(
   parameter int ADDR_LEN      = C_ADDR_LEN,
   parameter int REG_FILE_SIZE = C_REG_FILE_SIZE
) (
   input  wire logic                clk,
   input  wire logic                rst,
   input  wire logic                en,
   output      logic                wrEn,
   output      logic [ADDR_LEN-1:0] addr,
   output      logic                done
);

   localparam logic [ADDR_LEN-1:0] C_LAST_IDX = ADDR_LEN'(REG_FILE_SIZE - 1);

   logic [ADDR_LEN-1:0] r_clearIdx;

   // Advance the clear index once per enabled cycle, parking on the last one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clearIdx <= ADDR_LEN'(1);
      end else if (en && !done) begin
         r_clearIdx <= r_clearIdx + ADDR_LEN'(1);
      end
   end

   assign addr = r_clearIdx;
   assign done = (r_clearIdx == C_LAST_IDX);
   // Index 0 is never a legal write target, even if the counter were to wrap
   assign wrEn = en && (r_clearIdx != '0);

endmodule
`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : reg_wb_arbiter
// Description : Owns the single register-file write port. Clears the file
//               after reset, then arbitrates between the write-back stage
//               (fixed priority) and the custom-instruction unit (valid/ready)
//               with a starvation-driven one-cycle forced grant.
// Revision    : 1.0 - initial release
//==============================================================================
module reg_wb_arbiter
   import reg_wb_arbiter_pkg::*;
#(
   parameter int WORD_LEN      = C_WORD_LEN,
   parameter int ADDR_LEN      = C_ADDR_LEN,
   parameter int REG_FILE_SIZE = C_REG_FILE_SIZE,
   parameter int STARVE_LIMIT  = C_STARVE_LIMIT
) (
   input  wire logic          clk,
   input  wire logic          rst,
   reg_wb_arbiter_if.slave    bus
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_LIMIT);

   arb_state_t          r_state;
   arb_state_t          w_stateNext;
   logic [CNT_W-1:0]    r_starveCnt;
   logic [CNT_W-1:0]    w_starveNext;
   logic [CNT_W-1:0]    w_starveInc;

   logic                w_wrEn;
   logic [ADDR_LEN-1:0] w_wrDest;
   logic [WORD_LEN-1:0] w_wrVal;
   logic                w_cuReady;

   logic                r_regWriteEn;
   logic [ADDR_LEN-1:0] r_regDest;
   logic [WORD_LEN-1:0] r_regWriteVal;

   logic                w_clearEn;
   logic                w_clearWrEn;
   logic [ADDR_LEN-1:0] w_clearAddr;
   logic                w_clearDone;

   logic                w_wbGrant;
   logic                w_cuWritable;

   assign w_clearEn    = (r_state == ST_CLEAR);
   // A write-back to register 0 is not a request at all; it is dropped
   assign w_wbGrant    = bus.wbEn && (bus.wbDest != '0);
   assign w_cuWritable = bus.cuValid && (bus.cuDest != '0);
   assign w_starveInc  = r_starveCnt + CNT_W'(1);

   reg_clear_seq #(
      .ADDR_LEN      (ADDR_LEN),
      .REG_FILE_SIZE (REG_FILE_SIZE)
   ) u_clear_seq (
      .clk  (clk),
      .rst  (rst),
      .en   (w_clearEn),
      .wrEn (w_clearWrEn),
      .addr (w_clearAddr),
      .done (w_clearDone)
   );

   // Next state, starvation count, custom-unit handshake and write selection
   always_comb begin
      w_stateNext  = r_state;
      w_starveNext = r_starveCnt;
      w_cuReady    = 1'b0;
      w_wrEn       = 1'b0;
      w_wrDest     = r_regDest;
      w_wrVal      = r_regWriteVal;

      case (r_state)
         ST_CLEAR: begin
            w_wrEn   = w_clearWrEn;
            w_wrDest = w_clearAddr;
            w_wrVal  = '0;
            if (w_clearDone) begin
               w_stateNext = ST_RUN;
            end
         end

         ST_RUN: begin
            if (w_wbGrant) begin
               w_wrEn   = 1'b1;
               w_wrDest = bus.wbDest;
               w_wrVal  = bus.wbVal;
               if (bus.cuValid) begin
                  w_starveNext = w_starveInc;
                  if (w_starveInc == C_STARVE_MAX) begin
                     w_stateNext = ST_FORCE;
                  end
               end else begin
                  w_starveNext = '0;
               end
            end else begin
               // Port is free: accept any custom result, write only real dests
               w_cuReady    = bus.cuValid;
               w_starveNext = '0;
               if (w_cuWritable) begin
                  w_wrEn   = 1'b1;
                  w_wrDest = bus.cuDest;
                  w_wrVal  = bus.cuVal;
               end
            end
         end

         ST_FORCE: begin
            // Pipeline is frozen, so write-back will be re-presented next cycle
            w_cuReady    = bus.cuValid;
            w_starveNext = '0;
            w_stateNext  = ST_RUN;
            if (w_cuWritable) begin
               w_wrEn   = 1'b1;
               w_wrDest = bus.cuDest;
               w_wrVal  = bus.cuVal;
            end
         end

         default: begin
            w_stateNext  = ST_CLEAR;
            w_starveNext = '0;
         end
      endcase
   end

   // State and starvation counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_CLEAR;
         r_starveCnt <= '0;
      end else begin
         r_state     <= w_stateNext;
         r_starveCnt <= w_starveNext;
      end
   end

   // Registered register-file write port; address/data hold when idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_regWriteEn  <= 1'b0;
         r_regDest     <= '0;
         r_regWriteVal <= '0;
      end else begin
         r_regWriteEn <= w_wrEn;
         if (w_wrEn) begin
            r_regDest     <= w_wrDest;
            r_regWriteVal <= w_wrVal;
         end
      end
   end

   assign bus.cuReady     = w_cuReady;
   assign bus.stall       = (r_state != ST_RUN);
   assign bus.busy        = (r_state == ST_CLEAR);
   assign bus.regWriteEn  = r_regWriteEn;
   assign bus.regDest     = r_regDest;
   assign bus.regWriteVal = r_regWriteVal;

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_reg_wb_arbiter
// Description : Self-checking bench for reg_wb_arbiter: directed scenarios plus
//               random traffic against a behavioural model of the arbitration
//               rules and a shadow register file.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_reg_wb_arbiter;
   import reg_wb_arbiter_pkg::*;

   localparam int LIMIT = 4;
   localparam int NREG  = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   reg_wb_arbiter_if bus ();

   reg_wb_arbiter #(
      .WORD_LEN      (32),
      .ADDR_LEN      (5),
      .REG_FILE_SIZE (NREG),
      .STARVE_LIMIT  (LIMIT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model
   int          m_clearLeft;
   int          m_nextClr;
   bit          m_force;
   int          m_denied;
   logic        m_wen;
   logic [4:0]  m_dest;
   logic [31:0] m_val;

   logic [31:0] rf_dut [NREG];
   logic [31:0] rf_ref [NREG];

   // Random custom-unit request, held while not accepted
   logic        c_v;
   logic [4:0]  c_d;
   logic [31:0] c_val;
   logic        last_rdy;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_clearLeft = NREG - 1;
      m_nextClr   = 1;
      m_force     = 1'b0;
      m_denied    = 0;
      m_wen       = 1'b0;
      m_dest      = '0;
      m_val       = '0;
   endtask

   task automatic check_reset_outputs();
      check("rst_regWriteEn",  32'(bus.regWriteEn),  32'd0);
      check("rst_regDest",     32'(bus.regDest),     32'd0);
      check("rst_regWriteVal", bus.regWriteVal,      32'd0);
      check("rst_stall",       32'(bus.stall),       32'd1);
      check("rst_busy",        32'(bus.busy),        32'd1);
      check("rst_cuReady",     32'(bus.cuReady),     32'd0);
   endtask

   // Register file commits the registered write on the falling edge
   always @(negedge clk) begin
      if (!rst && bus.regWriteEn === 1'b1) rf_dut[bus.regDest] = bus.regWriteVal;
   end

   // One clock cycle: drive inputs, check combinational outputs, predict, check registered outputs
   task automatic step(input logic we, input logic [4:0] wd, input logic [31:0] wv,
                       input logic cv, input logic [4:0] cd, input logic [31:0] cvv,
                       output logic rdy);
      logic        e_stall, e_busy, e_rdy;
      logic        n_wen;
      logic [4:0]  n_dest;
      logic [31:0] n_val;
      // the write presented last cycle survived to its commit edge
      if (m_wen) rf_ref[m_dest] = m_val;
      bus.wbEn = we;  bus.wbDest = wd;  bus.wbVal = wv;
      bus.cuValid = cv; bus.cuDest = cd; bus.cuVal = cvv;
      #1;
      e_stall = (m_clearLeft > 0) || m_force;
      e_busy  = (m_clearLeft > 0);
      e_rdy   = 1'b0;
      n_wen   = 1'b0;
      n_dest  = m_dest;
      n_val   = m_val;
      if (m_clearLeft > 0) begin
         n_wen  = 1'b1;
         n_dest = 5'(m_nextClr);
         n_val  = '0;
         m_nextClr++;
         m_clearLeft--;
      end else if (m_force) begin
         e_rdy = cv;
         if (cv && cd != 0) begin n_wen = 1'b1; n_dest = cd; n_val = cvv; end
         m_force  = 1'b0;
         m_denied = 0;
      end else if (we && wd != 0) begin
         n_wen = 1'b1; n_dest = wd; n_val = wv;
         if (cv) begin
            m_denied++;
            if (m_denied == LIMIT) begin
               m_force  = 1'b1;
               m_denied = 0;
            end
         end else begin
            m_denied = 0;
         end
      end else begin
         e_rdy    = cv;
         m_denied = 0;
         if (cv && cd != 0) begin n_wen = 1'b1; n_dest = cd; n_val = cvv; end
      end
      check("stall",   32'(bus.stall),   32'(e_stall));
      check("busy",    32'(bus.busy),    32'(e_busy));
      check("cuReady", 32'(bus.cuReady), 32'(e_rdy));
      m_wen  = n_wen;
      m_dest = n_dest;
      m_val  = n_val;
      rdy    = e_rdy;
      @(posedge clk);
      #1;
      check("regWriteEn",  32'(bus.regWriteEn), 32'(m_wen));
      check("regDest",     32'(bus.regDest),    32'(m_dest));
      check("regWriteVal", bus.regWriteVal,     m_val);
   endtask

   task automatic new_cu_req();
      c_v   = ($urandom_range(0, 2) != 0);
      c_d   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      c_val = $urandom;
   endtask

   task automatic rand_step();
      logic        we;
      logic [4:0]  wd;
      logic [31:0] wv;
      we = ($urandom_range(0, 3) != 0);
      wd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wv = $urandom;
      step(we, wd, wv, c_v, c_d, c_val, last_rdy);
      if (!(c_v && !last_rdy)) new_cu_req();
   endtask

   // Asynchronous reset pulse between clock edges
   task automatic pulse_reset();
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs();
      model_reset();
      @(posedge clk);
      #1;
      check_reset_outputs();
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < NREG; i++) begin
         rf_dut[i] = 32'hBAD0_0000 + 32'(i);
         rf_ref[i] = 32'hBAD0_0000 + 32'(i);
      end
      bus.wbEn = 1'b0; bus.wbDest = '0; bus.wbVal = '0;
      bus.cuValid = 1'b0; bus.cuDest = '0; bus.cuVal = '0;
      model_reset();
      new_cu_req();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs();
      rst = 1'b0;

      // Full clear sequence with random (ignored) requests
      repeat (NREG - 1) rand_step();

      // Plain write-back
      step(1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 32'h0, last_rdy);
      // Starvation: four denied cycles then one forced grant
      repeat (LIMIT + 1) step(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd7, 32'h1234, last_rdy);
      step(1'b1, 5'd3, 32'hAAAA, 1'b0, 5'd0, 32'h0, last_rdy);
      // Write-back to r0 is dropped, custom unit takes the port
      step(1'b1, 5'd0, 32'h5555, 1'b1, 5'd9, 32'h9999, last_rdy);
      // Custom result to r0: handshake only
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h7777, last_rdy);

      new_cu_req();
      repeat (400) rand_step();

      // Reset in the middle of clearing (index 12 pending)
      pulse_reset();
      repeat (11) rand_step();
      pulse_reset();
      repeat (NREG - 1) rand_step();

      // Reset while in the forced-grant cycle
      repeat (LIMIT) step(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd7, 32'h1234, last_rdy);
      pulse_reset();
      new_cu_req();
      repeat (NREG - 1) rand_step();
      repeat (200) rand_step();
      repeat (2) step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, last_rdy);

      @(negedge clk);
      #1;
      if (m_wen) rf_ref[m_dest] = m_val;
      for (int i = 0; i < NREG; i++) check($sformatf("rf[%0d]", i), rf_dut[i], rf_ref[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
